// File: rtl/bignum_pkg.sv
// Shared types for the streaming big-number datapath blocks.
package bignum_pkg;
  localparam int DEF_REGISTER_SIZE = 32;

  typedef logic [DEF_REGISTER_SIZE-1:0] block_t;

  typedef enum logic [1:0] {IDLE, PAD, DRAIN} shift_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head is valid combinationally whenever !empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: nothing reads it until the count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/left_shifter.sv
// Streaming multiply by 2^SHIFT_BY: emits SHIFT_BY/REGISTER_SIZE zero blocks,
// then the buffered operand blocks, LSB block first.
module left_shifter
  import bignum_pkg::*;
#(
  parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
  parameter int NUM_BLOCKS    = 128,
  parameter int SHIFT_BY      = 4096,
  parameter int FIFO_DEPTH    = 256
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] block_in,
  output logic                     ready_out,
  output logic                     valid_out,
  output logic [REGISTER_SIZE-1:0] data_block_out,
  output logic                     overflow_out
);
  localparam int BLOCKS_TO_INSERT = SHIFT_BY / REGISTER_SIZE;
  localparam int PW = $clog2(BLOCKS_TO_INSERT) + 1;
  localparam int OW = $clog2(NUM_BLOCKS) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  shift_state_e             state_q, state_d;
  logic [PW-1:0]            pad_cnt_q, pad_cnt_d;
  logic [OW-1:0]            out_cnt_q, out_cnt_d;
  logic                     valid_q, valid_d;
  logic [REGISTER_SIZE-1:0] data_q, data_d;
  logic                     ovf_q, ovf_d;

  logic                     fifo_full, fifo_empty, push, pop, more;
  logic [REGISTER_SIZE-1:0] fifo_head;
  logic [CW-1:0]            fifo_cnt;

  assign push      = valid_in && !fifo_full;
  assign ready_out = !fifo_full;
  assign ovf_d     = ovf_q || (valid_in && fifo_full);
  // Another operand is pending if anything remains once this pop retires.
  assign more      = (fifo_cnt > CW'(1)) || push;

  sync_fifo #(.WIDTH(REGISTER_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (push),
    .pop   (pop),
    .din   (block_in),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      pad_cnt_q <= '0;
      out_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pad_cnt_q <= pad_cnt_d;
      out_cnt_q <= out_cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pad_cnt_d = pad_cnt_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      IDLE: begin
        if (push || !fifo_empty) begin
          state_d   = PAD;
          pad_cnt_d = PW'(BLOCKS_TO_INSERT);
        end
      end
      PAD: begin
        pad_cnt_d = pad_cnt_q - PW'(1);
        if (pad_cnt_q == PW'(1)) begin
          state_d   = DRAIN;
          out_cnt_d = OW'(NUM_BLOCKS);
        end
      end
      DRAIN: begin
        if (!fifo_empty) begin
          out_cnt_d = out_cnt_q - OW'(1);
          if (out_cnt_q == OW'(1)) begin
            if (more) begin
              state_d   = PAD;
              pad_cnt_d = PW'(BLOCKS_TO_INSERT);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      PAD: begin
        valid_d = 1'b1;
        data_d  = '0;
      end
      DRAIN: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          valid_d = 1'b1;
          data_d  = fifo_head;
        end
      end
      default: ;
    endcase
  end

  assign valid_out      = valid_q;
  assign data_block_out = data_q;
  assign overflow_out   = ovf_q;
endmodule

// File: tb/tb_left_shifter.sv
// Directed vector tables on small configurations plus a random check at default size.
module tb_left_shifter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small DUTs share stimulus; s_* has FIFO_DEPTH=4, o_* has FIFO_DEPTH=2.
  logic        rst, vin;
  logic [31:0] blk;
  logic        s_ready, s_valid, s_ovf, o_ready, o_valid, o_ovf;
  logic [31:0] s_data, o_data;

  logic        brst, bvin, bready, bvalid, bovf;
  logic [31:0] bblk, bdata;

  left_shifter #(.REGISTER_SIZE(32), .NUM_BLOCKS(4), .SHIFT_BY(64), .FIFO_DEPTH(4)) dut_s (
    .clk_in(clk), .rst_in(rst), .valid_in(vin), .block_in(blk),
    .ready_out(s_ready), .valid_out(s_valid), .data_block_out(s_data), .overflow_out(s_ovf));

  left_shifter #(.REGISTER_SIZE(32), .NUM_BLOCKS(4), .SHIFT_BY(64), .FIFO_DEPTH(2)) dut_o (
    .clk_in(clk), .rst_in(rst), .valid_in(vin), .block_in(blk),
    .ready_out(o_ready), .valid_out(o_valid), .data_block_out(o_data), .overflow_out(o_ovf));

  left_shifter dut_b (
    .clk_in(clk), .rst_in(brst), .valid_in(bvin), .block_in(bblk),
    .ready_out(bready), .valid_out(bvalid), .data_block_out(bdata), .overflow_out(bovf));

  typedef struct {
    logic        rst;
    logic        vin;
    logic [31:0] blk;
    logic        ev;
    logic [31:0] ed;
    logic        chk_rdy;
    logic        er;
    logic        eo;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;
  logic [31:0] A[4], B[4], C[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic v, input logic [31:0] b,
                              input logic ev, input logic [31:0] ed,
                              input logic cr, input logic er, input logic eo);
    vec_t e;
    e.rst = r; e.vin = v; e.blk = b; e.ev = ev; e.ed = ed;
    e.chk_rdy = cr; e.er = er; e.eo = eo;
    tbl.push_back(e);
  endfunction

  // Entry i drives edge i; ready is checked before that edge, outputs just after it.
  task automatic run_tbl(input string tag, input bit sel);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; vin = tbl[i].vin; blk = tbl[i].blk;
      #1;
      if (tbl[i].chk_rdy)
        chk($sformatf("%s[%0d].ready", tag, i), 32'(sel ? o_ready : s_ready), 32'(tbl[i].er));
      @(posedge clk); #1;
      chk($sformatf("%s[%0d].valid", tag, i), 32'(sel ? o_valid : s_valid), 32'(tbl[i].ev));
      if (tbl[i].ev)
        chk($sformatf("%s[%0d].data", tag, i), sel ? o_data : s_data, tbl[i].ed);
      chk($sformatf("%s[%0d].ovf", tag, i), 32'(sel ? o_ovf : s_ovf), 32'(tbl[i].eo));
    end
    tbl.delete();
    vin = 1'b0; blk = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; vin = 1'b0; blk = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic void add_contig(input logic [31:0] X[4]);
    add(0, 1, X[0], 0, 0,    1, 1, 0);
    add(0, 1, X[1], 1, 0,    1, 1, 0);
    add(0, 1, X[2], 1, 0,    1, 1, 0);
    add(0, 1, X[3], 1, X[0], 1, 1, 0);
    add(0, 0, 0,    1, X[1], 0, 0, 0);
    add(0, 0, 0,    1, X[2], 0, 0, 0);
    add(0, 0, 0,    1, X[3], 0, 0, 0);
    add(0, 0, 0,    0, 0,    0, 0, 0);
    add(0, 0, 0,    0, 0,    0, 0, 0);
  endfunction

  logic [4095:0] x;
  logic [8191:0] res, expv;

  initial begin
    for (int k = 0; k < 4; k++) begin
      A[k] = 32'hA5A5_1000 + k;
      B[k] = 32'hB00B_2000 + k;
      C[k] = 32'hC3C3_3000 + k;
    end
    rst = 1'b1; vin = 1'b0; blk = '0;
    brst = 1'b1; bvin = 1'b0; bblk = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(s_valid), 0);
    chk("reset.data",  s_data, 0);
    chk("reset.ovf",   32'(s_ovf), 0);
    chk("reset.ready", 32'(s_ready), 1);
    chk("reset.bvalid", 32'(bvalid), 0);
    rst = 1'b0; brst = 1'b0;

    add_contig(A);
    run_tbl("contig", 0);
    do_reset();

    add(0, 1, A[0], 0, 0,    1, 1, 0);
    add(0, 0, 0,    1, 0,    0, 0, 0);
    add(0, 0, 0,    1, 0,    0, 0, 0);
    add(0, 0, 0,    1, A[0], 0, 0, 0);
    add(0, 0, 0,    0, 0,    0, 0, 0);
    add(0, 1, A[1], 0, 0,    1, 1, 0);
    add(0, 1, A[2], 1, A[1], 1, 1, 0);
    add(0, 1, A[3], 1, A[2], 1, 1, 0);
    add(0, 0, 0,    1, A[3], 0, 0, 0);
    add(0, 0, 0,    0, 0,    0, 0, 0);
    add(0, 0, 0,    0, 0,    0, 0, 0);
    run_tbl("gapped", 0);
    do_reset();

    add(0, 1, A[0], 0, 0,    1, 1, 0);
    add(0, 1, A[1], 1, 0,    1, 1, 0);
    add(0, 1, A[2], 1, 0,    1, 1, 0);
    add(0, 1, A[3], 1, A[0], 1, 1, 0);
    add(0, 1, B[0], 1, A[1], 1, 1, 0);
    add(0, 1, B[1], 1, A[2], 1, 1, 0);
    add(0, 1, B[2], 1, A[3], 1, 1, 0);
    add(0, 1, B[3], 1, 0,    1, 1, 0);
    add(0, 0, 0,    1, 0,    0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 1, B[k], 0, 0, 0);
    add(0, 0, 0,    0, 0,    0, 0, 0);
    add(0, 0, 0,    0, 0,    0, 0, 0);
    run_tbl("b2b", 0);
    do_reset();

    add(0, 1, A[0], 0, 0,    1, 1, 0);
    add(0, 1, A[1], 1, 0,    1, 1, 0);
    add(0, 1, A[2], 1, 0,    1, 0, 1);
    add(0, 1, A[3], 1, A[0], 1, 0, 1);
    add(0, 0, 0,    1, A[1], 0, 0, 1);
    add(0, 0, 0,    0, 0,    0, 0, 1);
    add(0, 0, 0,    0, 0,    0, 0, 1);
    add(1, 0, 0,    0, 0,    0, 0, 0);
    add(0, 0, 0,    0, 0,    1, 1, 0);
    run_tbl("ovf", 1);
    do_reset();

    // Async reset in the middle of the zero padding.
    vin = 1'b1; blk = A[0];
    @(posedge clk); #1;
    blk = A[1];
    @(posedge clk); #1;
    vin = 1'b0; blk = '0;
    chk("midpad.pre_valid", 32'(s_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("midpad.valid", 32'(s_valid), 0);
    chk("midpad.data",  s_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    add_contig(C);
    run_tbl("after_rst", 0);

    // Default configuration, random 4096-bit operands.
    for (int op = 0; op < 50; op++) begin
      int idx, got, cyc;
      logic acc;
      for (int k = 0; k < 128; k++) x[k*32 +: 32] = $urandom;
      idx = 0; got = 0; cyc = 0; res = '0;
      while (got < 256 && cyc < 1000) begin
        bvin = (idx < 128);
        bblk = (idx < 128) ? x[idx*32 +: 32] : 32'h0;
        #1;
        acc = bvin && bready;
        @(posedge clk); #1;
        if (acc) idx++;
        if (bvalid) begin
          res[got*32 +: 32] = bdata;
          got++;
        end
        cyc++;
      end
      bvin = 1'b0; bblk = '0;
      chk($sformatf("rand[%0d].count", op), 32'(got), 256);
      expv = {4096'b0, x} << 4096;
      total++;
      if (res !== expv) begin
        bad++;
        for (int k = 0; k < 256; k++)
          if (res[k*32 +: 32] !== expv[k*32 +: 32]) begin
            $display("FAIL rand[%0d].block%0d: got %h want %h", op, k,
                     res[k*32 +: 32], expv[k*32 +: 32]);
            break;
          end
      end
    end
    @(posedge clk); #1;
    chk("rand.idle_valid", 32'(bvalid), 0);
    chk("rand.ovf", 32'(bovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
